// File: rtl/multdiv_writeback_arbiter_pkg.sv
// Shared widths, entry layout and arbitration select encoding for the
// multdiv writeback arbiter and its result FIFO.
package multdiv_writeback_arbiter_pkg;

  localparam int MD_DEPTH      = 2;
  localparam int MD_STATUS_REG = 30;
  localparam int RD_W          = 5;
  localparam int DATA_W        = 32;
  localparam int TAG_W         = 5;
  localparam int ENTRY_W       = RD_W + DATA_W + TAG_W;

  // rd is the register actually written; tag is the issuing destination whose
  // pending bit the drain releases (they differ on overflow status writes).
  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } md_entry_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WB    = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_sel_e;

endpackage

// File: rtl/multdiv_writeback_arbiter_fifo.sv
// Small FIFO holding completed mult/div results until the register-file
// write port is free. A push into a full FIFO is accepted only with a pop.
module md_result_fifo
  import multdiv_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = MD_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  md_entry_t        push_entry,
  input  logic             pop,
  output md_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  md_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multdiv_writeback_arbiter.sv
// Merges queued mult/div results with the pipeline writeback onto the single
// register-file write port and tracks pending destinations for decode.
module multdiv_writeback_arbiter
  import multdiv_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH      = MD_DEPTH,
  parameter int STATUS_REG = MD_STATUS_REG
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              md_issue,
  input  logic [RD_W-1:0]   md_issue_rd,
  input  logic              md_rdy,
  input  logic [RD_W-1:0]   md_rd,
  input  logic [DATA_W-1:0] md_data,
  input  logic              wb_we,
  input  logic [RD_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [RD_W-1:0]   dec_rs,
  input  logic [RD_W-1:0]   dec_rt,
  output logic              rf_we,
  output logic [RD_W-1:0]   rf_rd,
  output logic [DATA_W-1:0] rf_data,
  output logic              wb_stall,
  output logic              dec_stall,
  output logic [1:0]        fifo_count,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [RD_W-1:0] STATUS_RD = RD_W'(STATUS_REG);

  // Handshake: md_rdy is a one-cycle pulse and is always accepted into the
  // FIFO; wb_we is held by the pipeline while wb_stall is high and counts as
  // written in any cycle where wb_we=1 and wb_stall=0.

  logic             in_flight;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      pending;
  logic [31:0]      pending_next;
  logic [31:0]      set_mask;
  logic [31:0]      clr_mask;
  logic             proto_err_q;
  logic             proto_err_set;
  logic             issue_ok;

  md_entry_t        push_entry;
  md_entry_t        head;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  arb_sel_e         arb_sel;

  assign push_entry = '{rd: md_rd, data: md_data, tag: (in_flight ? tag_q : '0)};

  md_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .clr        (clr),
    .push       (md_rdy),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // A full FIFO takes the port so the next md_rdy always finds room.
  always_comb begin
    arb_sel = ARB_IDLE;
    if (fifo_full)        arb_sel = ARB_DRAIN;
    else if (wb_we)       arb_sel = ARB_WB;
    else if (!fifo_empty) arb_sel = ARB_DRAIN;
  end

  assign pop = clr && (arb_sel == ARB_DRAIN);

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_data  = '0;
    wb_stall = 1'b0;
    if (clr) begin
      case (arb_sel)
        ARB_WB: begin
          rf_we   = (wb_rd != '0);
          rf_rd   = wb_rd;
          rf_data = wb_data;
        end
        ARB_DRAIN: begin
          rf_we    = (head.rd != '0);
          rf_rd    = head.rd;
          rf_data  = head.data;
          wb_stall = wb_we && fifo_full;
        end
        default: ;
      endcase
    end
  end

  // A second issue is only legal when the in-flight op completes that cycle.
  assign issue_ok      = md_issue && (!in_flight || md_rdy);
  assign proto_err_set = (md_issue && in_flight && !md_rdy)
                       || (md_rdy && !in_flight)
                       || (md_rdy && fifo_full && !pop);

  assign set_mask     = (issue_ok && (md_issue_rd != '0)) ? (32'd1 << md_issue_rd) : 32'd0;
  assign clr_mask     = pop ? (32'd1 << head.tag) : 32'd0;
  assign pending_next = (pending & ~clr_mask) | set_mask;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      in_flight   <= 1'b0;
      tag_q       <= '0;
      pending     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (issue_ok) begin
        tag_q     <= md_issue_rd;
        in_flight <= 1'b1;
      end else if (md_rdy) begin
        in_flight <= 1'b0;
      end
      pending <= pending_next;
      if (proto_err_set) proto_err_q <= 1'b1;
    end
  end

  always_comb begin
    dec_stall = 1'b0;
    if (clr) begin
      dec_stall = pending[dec_rs] || pending[dec_rt]
               || (((dec_rs == STATUS_RD) || (dec_rt == STATUS_RD)) && (in_flight || !fifo_empty));
    end
  end

  assign fifo_count = 2'(count);
  assign proto_err  = proto_err_q;

endmodule
